// File: rtl/mpyacc_multi_stage_pkg.sv
// Shared definitions for the multiply-accumulate macrocell family:
// accumulate-mode encoding and the parameter legality check.
package mpyacc_multi_stage_pkg;

    typedef enum logic {
        MPYACC_LOAD = 1'b0,
        MPYACC_ADD  = 1'b1
    } acc_mode_e;

    function automatic bit mpyacc_cfg_ok(
        input int numstage,
        input int inwidth0,
        input int inwidth1,
        input int accwidth,
        input int outwidth,
        input int outlsb
    );
        return (numstage >= 3)
            && (accwidth >= inwidth0 + inwidth1)
            && (outwidth >= 1)
            && (outwidth + outlsb <= accwidth);
    endfunction

endpackage

// File: rtl/mpyacc_multi_stage_delay_line.sv
// Enable-gated shift register with an async-reset, flushable valid lane.
// Data lanes carry no reset; a data word is only consumed alongside its valid bit.
module mpyacc_multi_stage_delay_line
    import mpyacc_multi_stage_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enable,
    input  logic             vin,
    input  logic [width-1:0] din,
    output logic             vout,
    output logic [width-1:0] dout
);

    logic [width-1:0] data_q [depth];
    logic [width-1:0] data_d [depth];
    logic [depth-1:0] vld_q;
    logic [depth-1:0] vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (enable) begin
            data_d[0] = din;
            vld_d[0]  = vin;
            for (int i = 1; i < depth; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign vout = vld_q[depth-1];
    assign dout = data_q[depth-1];

endmodule

// File: rtl/mpyacc_multi_stage.sv
// Pipelined multiply-accumulate: input regs, product pipe, accumulator, output slice.
// Define MPYACC_SATURATE_EN to clamp o0 to its range and report o0_ovf.
module mpyacc_multi_stage
    import mpyacc_multi_stage_pkg::*;
#(
    parameter int inwidth0  = 4,
    parameter int inwidth1  = 4,
    parameter int accwidth  = 16,
    parameter int outwidth  = 8,
    parameter int outlsb    = 0,
    parameter int numstage  = 3,
    parameter bit signed_op = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                enable,
    input  logic                pred,
    input  logic                acc_add,
    input  logic [inwidth0-1:0] i0,
    input  logic [inwidth1-1:0] i1,
    output logic                o0_enable,
    output logic [outwidth-1:0] o0,
    output logic                o0_ovf
);

    localparam int PW    = inwidth0 + inwidth1;
    localparam int DEPTH = numstage - 2;
    localparam int DW    = accwidth + 1;

    if (!mpyacc_cfg_ok(numstage, inwidth0, inwidth1,
                       accwidth, outwidth, outlsb)) begin : g_cfg_err
        $error("mpyacc_multi_stage: illegal parameter set");
    end

    logic [inwidth0-1:0] i0_q, i0_d;
    logic [inwidth1-1:0] i1_q, i1_d;
    logic                add_q, add_d;
    logic                vld1_q, vld1_d;

    always_comb begin
        i0_d   = enable ? i0 : i0_q;
        i1_d   = enable ? i1 : i1_q;
        add_d  = enable ? acc_add : add_q;
        vld1_d = enable ? pred : vld1_q;
        if (flush) begin
            vld1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        i0_q  <= i0_d;
        i1_q  <= i1_d;
        add_q <= add_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= vld1_d;
        end
    end

    logic [accwidth-1:0] prod_ext;

    if (signed_op) begin : g_mul_signed
        logic signed [PW-1:0] prod_s;
        assign prod_s   = PW'($signed(i0_q)) * PW'($signed(i1_q));
        assign prod_ext = accwidth'(prod_s);
    end else begin : g_mul_unsigned
        logic [PW-1:0] prod_u;
        assign prod_u   = PW'(i0_q) * PW'(i1_q);
        assign prod_ext = accwidth'(prod_u);
    end

    logic          pv;
    logic [DW-1:0] pd;

    mpyacc_multi_stage_delay_line #(
        .width (DW),
        .depth (DEPTH)
    ) u_prod_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .enable (enable),
        .vin    (vld1_q),
        .din    ({add_q, prod_ext}),
        .vout   (pv),
        .dout   (pd)
    );

    logic [accwidth-1:0] acc_q, acc_d;
    logic                o0_enable_q, o0_enable_d;
    logic [accwidth-1:0] pprod;
    acc_mode_e           pmode;

    assign pprod = pd[accwidth-1:0];
    assign pmode = acc_mode_e'(pd[accwidth]);

    // The accumulator is a single stage, so back-to-back adds see the prior sum.
    always_comb begin
        acc_d       = acc_q;
        o0_enable_d = o0_enable_q;
        if (flush) begin
            acc_d       = '0;
            o0_enable_d = 1'b0;
        end else if (enable) begin
            o0_enable_d = pv;
            if (pv) begin
                acc_d = (pmode == MPYACC_ADD) ? acc_q + pprod : pprod;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            o0_enable_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            o0_enable_q <= o0_enable_d;
        end
    end

    assign o0_enable = o0_enable_q;

`ifdef MPYACC_SATURATE_EN
    localparam logic [accwidth-1:0] SMAX =
        (accwidth'(1) << (outwidth - 1)) - accwidth'(1);
    localparam logic [accwidth-1:0] SMIN = ~SMAX;

    logic [accwidth-1:0] sh;

    always_comb begin
        o0_ovf = 1'b0;
        if (signed_op) begin
            sh = accwidth'($signed(acc_q) >>> outlsb);
            o0 = sh[outwidth-1:0];
            if ($signed(sh) > $signed(SMAX)) begin
                o0     = SMAX[outwidth-1:0];
                o0_ovf = 1'b1;
            end else if ($signed(sh) < $signed(SMIN)) begin
                o0     = SMIN[outwidth-1:0];
                o0_ovf = 1'b1;
            end
        end else begin
            sh = acc_q >> outlsb;
            o0 = sh[outwidth-1:0];
            if (|(sh >> outwidth)) begin
                o0     = '1;
                o0_ovf = 1'b1;
            end
        end
    end
`else
    logic acc_unused;

    assign acc_unused = ^acc_q;
    assign o0         = acc_q[outwidth+outlsb-1:outlsb];
    assign o0_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_mpyacc_multi_stage.sv
// Scoreboard bench for mpyacc_multi_stage: unsigned 4-stage and signed 3-stage
// instances driven with directed vectors.
module tb_mpyacc_multi_stage;

    localparam int NS = 4;

`ifdef MPYACC_SATURATE_EN
    localparam logic [7:0] SAT450 = 8'd255;
    localparam logic       OVF450 = 1'b1;
`else
    localparam logic [7:0] SAT450 = 8'd194;
    localparam logic       OVF450 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       enable = 1'b0;
    logic       pred = 1'b0;
    logic       acc_add = 1'b0;
    logic [3:0] i0 = '0;
    logic [3:0] i1 = '0;
    logic       o0_enable;
    logic [7:0] o0;
    logic       o0_ovf;

    logic       s_pred = 1'b0;
    logic       s_acc_add = 1'b0;
    logic [3:0] s_i0 = '0;
    logic [3:0] s_i1 = '0;
    logic       s_o0_enable;
    logic [7:0] s_o0;
    logic       s_o0_ovf;

    mpyacc_multi_stage #(
        .inwidth0 (4), .inwidth1 (4), .accwidth (16),
        .outwidth (8), .outlsb (0), .numstage (NS), .signed_op (1'b0)
    ) dut (
        .clk (clk), .reset (reset), .flush (flush), .enable (enable),
        .pred (pred), .acc_add (acc_add), .i0 (i0), .i1 (i1),
        .o0_enable (o0_enable), .o0 (o0), .o0_ovf (o0_ovf)
    );

    mpyacc_multi_stage #(
        .inwidth0 (4), .inwidth1 (4), .accwidth (16),
        .outwidth (8), .outlsb (0), .numstage (3), .signed_op (1'b1)
    ) dut_s (
        .clk (clk), .reset (reset), .flush (flush), .enable (enable),
        .pred (s_pred), .acc_add (s_acc_add), .i0 (s_i0), .i1 (s_i1),
        .o0_enable (s_o0_enable), .o0 (s_o0), .o0_ovf (s_o0_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic       ovf;
        int         edge_n;
    } exp_t;

    exp_t q[$];
    exp_t sq[$];
    int   checks = 0;
    int   errors = 0;
    int   en_edges = 0;
    int   cyc = 0;
    int   last_ret_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a retire is an enabled edge after which o0_enable is high.
    exp_t x;
    exp_t sx;
    logic e_s;
    logic r_s;
    always begin
        @(posedge clk);
        e_s = enable;
        r_s = reset;
        #1;
        if (!r_s && !reset) begin
            cyc++;
            if (e_s) en_edges++;
            if (e_s && o0_enable) begin
                last_ret_cyc = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_retire", 0, 1);
                end else begin
                    x = q.pop_front();
                    chk("o0", o0, x.o);
                    chk("o0_ovf", o0_ovf, x.ovf);
                    chk("latency", en_edges, x.edge_n);
                end
            end
            if (e_s && s_o0_enable) begin
                if (sq.size() == 0) begin
                    chk("s_unexpected_retire", 0, 1);
                end else begin
                    sx = sq.pop_front();
                    chk("s_o0", s_o0, sx.o);
                    chk("s_o0_ovf", s_o0_ovf, sx.ovf);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic add, input logic [7:0] eo,
                         input logic eovf, input bit push);
        @(negedge clk);
        pred    = 1'b1;
        i0      = a;
        i1      = b;
        acc_add = add;
        if (push) q.push_back('{eo, eovf, en_edges + NS});
    endtask

    task automatic s_issue(input logic [3:0] a, input logic [3:0] b,
                           input logic add, input logic [7:0] eo);
        @(negedge clk);
        s_pred    = 1'b1;
        s_i0      = a;
        s_i1      = b;
        s_acc_add = add;
        sq.push_back('{eo, 1'b0, 0});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pred   = 1'b0;
            s_pred = 1'b0;
        end
    endtask

    int issue_cyc;

    initial begin
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_o0", o0, 0);
        chk("rst_o0_enable", o0_enable, 0);
        chk("rst_o0_ovf", o0_ovf, 0);
        reset = 1'b0;

        issue(4'd3, 4'd5, 1'b0, 8'd15, 1'b0, 1);
        idle(6);

        issue(4'd2, 4'd3, 1'b0, 8'd6, 1'b0, 1);
        issue(4'd4, 4'd4, 1'b1, 8'd22, 1'b0, 1);
        issue(4'd1, 4'd7, 1'b1, 8'd29, 1'b0, 1);
        idle(6);

        s_issue(4'hD, 4'd5, 1'b0, 8'hF1);
        s_issue(4'h8, 4'h8, 1'b0, 8'd64);
        s_issue(4'hF, 4'd7, 1'b1, 8'd57);
        idle(5);

        issue(4'd2, 4'd2, 1'b0, 8'd4, 1'b0, 1);
        issue_cyc = cyc;
        @(negedge clk);
        pred = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", o0, 29);
        end
        enable = 1'b1;
        idle(5);
        chk("stall_latency", last_ret_cyc - issue_cyc, 7);

        issue(4'd5, 4'd5, 1'b0, 8'd0, 1'b0, 0);
        issue(4'd6, 4'd6, 1'b0, 8'd0, 1'b0, 0);
        @(negedge clk);
        pred  = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_o0", o0, 0);
        chk("flush_o0_enable", o0_enable, 0);
        idle(6);
        chk("flush_o0_later", o0, 0);
        issue(4'd1, 4'd9, 1'b1, 8'd9, 1'b0, 1);
        idle(6);

        issue(4'd15, 4'd15, 1'b0, 8'd225, 1'b0, 1);
        issue(4'd15, 4'd15, 1'b1, SAT450, OVF450, 1);
        idle(6);
        chk("sat_hold_o0", o0, SAT450);
        chk("sat_hold_ovf", o0_ovf, OVF450);

        issue(4'd1, 4'd1, 1'b1, SAT450 + ((OVF450) ? 8'd0 : 8'd1),
              OVF450, 1);
        issue(4'd2, 4'd2, 1'b1, 8'd0, 1'b0, 0);
        idle(1);
        repeat (2) @(negedge clk);
        chk("pre_rst_o0_enable", o0_enable, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_o0", o0, 0);
        chk("async_rst_o0_enable", o0_enable, 0);
        chk("async_rst_o0_ovf", o0_ovf, 0);
        chk("async_rst_s_o0", s_o0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(6);
        chk("post_rst_o0", o0, 0);

        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0 && sq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_q", q.size(), 0);
        chk("drain_sq", sq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
